io_terminal_unit: RTL

IO_TERMINAL_UNIT -- requirements
Module: io_terminal_unit

---
 rtl/io_terminal_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/io_terminal_unit.sv
// rtl/io_terminal_unit.sv - device side of the INPR/FGI/OUTR/FGO port: keyboard FIFO in, printer handshake out
module io_terminal_unit #(
    parameter int KBD_DEPTH = 4,
    parameter int PRN_GAP   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] kbd_data,
    input  logic       kbd_valid,
    output logic       kbd_ready,
    output logic [7:0] inpr,
    output logic       fgi,
    input  logic       inp_ack,
    input  logic [7:0] outr_data,
    input  logic       out_ack,
    output logic [7:0] outr,
    output logic       fgo,
    output logic [7:0] prn_data,
    output logic       prn_valid,
    input  logic       prn_ready,
    input  logic       ien,
    output logic       irq
);

    localparam int          AW         = $clog2(KBD_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(KBD_DEPTH);
    localparam logic [3:0]  GAP_LOAD   = (PRN_GAP == 0) ? 4'd0 : 4'(PRN_GAP - 1);
    localparam bit          HAS_GAP    = (PRN_GAP != 0);

    logic [7:0]    mem [KBD_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // Ready depends only on state, so a same-cycle pop never frees a slot early.
    assign kbd_ready = (count != FULL_COUNT);
    assign push      = kbd_valid && kbd_ready;
    assign pop       = !fgi && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= kbd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            inpr   <= 8'h00;
            fgi    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // pop requires fgi=0, so it never competes with the INP acknowledge.
            if (pop) begin
                inpr <= mem[rd_ptr];
                fgi  <= 1'b1;
            end else if (inp_ack && fgi) begin
                fgi <= 1'b0;
            end
        end
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } out_state_t;

    out_state_t state;
    out_state_t next_state;
    logic [3:0] gap_cnt;
    logic [3:0] next_gap_cnt;
    logic       load_outr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gap_cnt <= 4'd0;
            outr    <= 8'h00;
        end else begin
            state   <= next_state;
            gap_cnt <= next_gap_cnt;
            if (load_outr) begin
                outr <= outr_data;
            end
        end
    end

    always_comb begin
        next_state   = state;
        next_gap_cnt = gap_cnt;
        load_outr    = 1'b0;
        case (state)
            IDLE: begin
                if (out_ack) begin
                    load_outr  = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (prn_ready) begin
                    if (HAS_GAP) begin
                        next_state   = GAP;
                        next_gap_cnt = GAP_LOAD;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    next_state = IDLE;
                end else begin
                    next_gap_cnt = gap_cnt - 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Flags decode straight from registered state so reset drops prn_valid immediately.
    assign fgo       = (state == IDLE);
    assign prn_valid = (state == SEND);
    assign prn_data  = outr;
    assign irq       = ien && (fgi || fgo);

endmodule
